// File: rtl/ad9254_spi_ctrl_if.sv
// User-side configuration port of the AD9254 SPI controller.
// The master modport is the requester; the slave modport is the controller.
interface ad9254_spi_ctrl_if;
    logic        cfg_req;
    logic        cfg_wr;
    logic [12:0] cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        cfg_ack;
    logic [7:0]  cfg_rdata;
    logic        cfg_busy;

    modport master (
        output cfg_req,
        output cfg_wr,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_ack,
        input  cfg_rdata,
        input  cfg_busy
    );

    modport slave (
        input  cfg_req,
        input  cfg_wr,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_ack,
        output cfg_rdata,
        output cfg_busy
    );
endinterface

// File: rtl/ad9254_spi_ctrl.sv
// AD9254 3-wire SPI configuration master. After reset it plays a fixed
// three-entry init table, then serves single-register read/write requests.
// All SPI pins come straight from flops so they cannot glitch.
module ad9254_spi_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    ad9254_spi_ctrl_if.slave cfg,
    output logic             init_done,
    output logic             adc_sclk,
    output logic             adc_cs_n,
    output logic             adc_sdio_o,
    output logic             adc_sdio_oe,
    input  logic             adc_sdio_i
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYC - 1);
    localparam logic [1:0]       LAST_ENTRY = 2'd2;

    typedef enum logic [1:0] {INIT_LOAD, SHIFT, GAP, IDLE} state_t;

    state_t            state_q, state_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic              sclk_q, sclk_n;
    logic [4:0]        bit_q, bit_n;
    logic              tail_q, tail_n;
    logic [GAP_W-1:0]  gap_q, gap_n;
    logic [23:0]       shreg_q, shreg_n;
    logic [7:0]        rshift_q, rshift_n;
    logic              rd_q, rd_n;
    logic              user_q, user_n;
    logic [1:0]        idx_q, idx_n;
    logic              init_done_q, init_done_n;
    logic              busy_q, busy_n;
    logic              ack_q, ack_n;
    logic [7:0]        rdata_q, rdata_n;
    logic              cs_n_q, cs_n_n;
    logic              oe_q, oe_n;
    logic              start_frame;

    // Init table: {addr[12:0], data[7:0]}; every entry is a write.
    function automatic logic [20:0] init_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    init_entry = {13'h014, 8'h00};
            2'd1:    init_entry = {13'h009, 8'h01};
            default: init_entry = {13'h0FF, 8'h01};
        endcase
    endfunction

    // State and datapath registers; reset forces CSB high and SCLK low at once.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT_LOAD;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            bit_q       <= '0;
            tail_q      <= 1'b0;
            gap_q       <= '0;
            shreg_q     <= '0;
            rshift_q    <= '0;
            rd_q        <= 1'b0;
            user_q      <= 1'b0;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            cs_n_q      <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_n;
            div_q       <= div_n;
            sclk_q      <= sclk_n;
            bit_q       <= bit_n;
            tail_q      <= tail_n;
            gap_q       <= gap_n;
            shreg_q     <= shreg_n;
            rshift_q    <= rshift_n;
            rd_q        <= rd_n;
            user_q      <= user_n;
            idx_q       <= idx_n;
            init_done_q <= init_done_n;
            busy_q      <= busy_n;
            ack_q       <= ack_n;
            rdata_q     <= rdata_n;
            cs_n_q      <= cs_n_n;
            oe_q        <= oe_n;
        end
    end

    // Next-state logic: frame sequencing, bit timing, read capture and handshake.
    always_comb begin
        state_n     = state_q;
        div_n       = div_q;
        sclk_n      = sclk_q;
        bit_n       = bit_q;
        tail_n      = tail_q;
        gap_n       = gap_q;
        shreg_n     = shreg_q;
        rshift_n    = rshift_q;
        rd_n        = rd_q;
        user_n      = user_q;
        idx_n       = idx_q;
        init_done_n = init_done_q;
        busy_n      = busy_q;
        ack_n       = 1'b0;
        rdata_n     = rdata_q;
        start_frame = 1'b0;

        if (state_q == SHIFT && sclk_q && div_q == DIV_LAST && bit_q <= 5'd7) begin
            rshift_n = {rshift_q[6:0], adc_sdio_i};
        end

        case (state_q)
            INIT_LOAD: begin
                shreg_n     = {3'b000, init_entry(idx_q)};
                rd_n        = 1'b0;
                user_n      = 1'b0;
                start_frame = 1'b1;
            end
            IDLE: begin
                if (cfg.cfg_req && !ack_q) begin
                    shreg_n     = {!cfg.cfg_wr, 2'b00, cfg.cfg_addr,
                                   cfg.cfg_wr ? cfg.cfg_wdata : 8'h00};
                    rd_n        = !cfg.cfg_wr;
                    user_n      = 1'b1;
                    busy_n      = 1'b1;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_n = '0;
                    if (tail_q) begin
                        tail_n  = 1'b0;
                        gap_n   = '0;
                        state_n = GAP;
                    end else if (!sclk_q) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n  = 1'b0;
                        shreg_n = {shreg_q[22:0], 1'b0};
                        if (bit_q == 5'd0) begin
                            tail_n = 1'b1;
                        end else begin
                            bit_n = bit_q - 5'd1;
                        end
                    end
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (user_q) begin
                        ack_n   = 1'b1;
                        busy_n  = 1'b0;
                        user_n  = 1'b0;
                        state_n = IDLE;
                        if (rd_q) begin
                            rdata_n = rshift_q;
                        end
                    end else if (idx_q == LAST_ENTRY) begin
                        init_done_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        idx_n       = idx_q + 2'd1;
                        shreg_n     = {3'b000, init_entry(idx_q + 2'd1)};
                        start_frame = 1'b1;
                    end
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end
            default: state_n = INIT_LOAD;
        endcase

        if (start_frame) begin
            state_n = SHIFT;
            div_n   = '0;
            sclk_n  = 1'b0;
            bit_n   = 5'd23;
            tail_n  = 1'b0;
        end

        cs_n_n = (state_n != SHIFT);
        oe_n   = (state_n == SHIFT) && !(rd_n && bit_n <= 5'd7);
    end

    assign adc_sclk      = sclk_q;
    assign adc_cs_n      = cs_n_q;
    assign adc_sdio_o    = shreg_q[23];
    assign adc_sdio_oe   = oe_q;
    assign init_done     = init_done_q;
    assign cfg.cfg_ack   = ack_q;
    assign cfg.cfg_rdata = rdata_q;
    assign cfg.cfg_busy  = busy_q;
endmodule

// File: tb/tb_ad9254_spi_ctrl.sv
// Bench for ad9254_spi_ctrl: an SPI slave model records every frame, and
// directed vectors plus hand-written sequences check the controller.
module tb_ad9254_spi_ctrl;
    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 8;
    localparam int CSB_LOW = 98;

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  resp;
        logic [23:0] exp_frame;
        logic [7:0]  exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [23:0] frame;
        int          low;
        int          high_before;
        int          sdio_err;
        int          oe_err;
    } rec_t;

    logic sys_clk = 1'b0;
    logic reset_n;
    logic init_done, adc_sclk, adc_cs_n, adc_sdio_o, adc_sdio_oe;
    logic adc_sdio_i = 1'b0;

    ad9254_spi_ctrl_if cfg_bus();

    ad9254_spi_ctrl #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .cfg         (cfg_bus),
        .init_done   (init_done),
        .adc_sclk    (adc_sclk),
        .adc_cs_n    (adc_cs_n),
        .adc_sdio_o  (adc_sdio_o),
        .adc_sdio_oe (adc_sdio_oe),
        .adc_sdio_i  (adc_sdio_i)
    );

    always #5 sys_clk = ~sys_clk;

    int passed = 0;
    int total  = 0;

    rec_t        rec_q[$];
    logic [23:0] cur_frame;
    int          rises, cur_low, high_run, cur_high_before, sdio_err_c, oe_err_c;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1, in_frame = 1'b0;
    logic        frame_rd, held_sdio;
    logic [7:0]  model_resp;
    vec_t        vecs[6];
    logic [23:0] init_frames[3] = '{24'h001400, 24'h000901, 24'h00FF01};

    // SPI slave model: samples the bus mid-cycle, records frames and drives read data.
    always @(negedge sys_clk) begin
        if (!reset_n) begin
            in_frame   = 1'b0;
            prev_sclk  = 1'b0;
            prev_cs    = 1'b1;
            high_run   = 0;
            adc_sdio_i = 1'b0;
        end else begin
            if (adc_cs_n) high_run = prev_cs ? high_run + 1 : 1;
            if (prev_cs && !adc_cs_n) begin
                in_frame        = 1'b1;
                cur_frame       = '0;
                rises           = 0;
                cur_low         = 0;
                cur_high_before = high_run;
                sdio_err_c      = 0;
                oe_err_c        = 0;
            end
            if (!adc_cs_n) cur_low++;
            if (!prev_cs && adc_cs_n && in_frame) begin
                rec_q.push_back('{cur_frame, cur_low, cur_high_before, sdio_err_c, oe_err_c});
                in_frame = 1'b0;
            end
            if (!adc_cs_n && adc_sclk && !prev_sclk) begin
                cur_frame = {cur_frame[22:0], adc_sdio_o};
                rises++;
                held_sdio = adc_sdio_o;
                if (rises == 1) frame_rd = adc_sdio_o;
                if (adc_sdio_oe !== !(frame_rd && rises > 16)) oe_err_c++;
            end else if (!adc_cs_n && adc_sclk && prev_sclk) begin
                if (adc_sdio_o !== held_sdio) sdio_err_c++;
            end
            begin
                int idx;
                idx = adc_sclk ? rises - 1 : rises;
                if (!adc_cs_n && idx >= 16 && idx <= 23) adc_sdio_i = model_resp[23 - idx];
                else adc_sdio_i = 1'b0;
            end
            prev_sclk = adc_sclk;
            prev_cs   = adc_cs_n;
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic pop_rec(output rec_t r, output bit ok);
        ok = (rec_q.size() > 0);
        if (ok) r = rec_q.pop_front();
        else r = '{default: 0};
    endtask

    task automatic wait_ack(input int budget, output int lat, output bit seen, output bit busy_ok);
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < budget) begin
            tick();
            lat++;
            if (cfg_bus.cfg_ack) seen = 1'b1;
            else if (!cfg_bus.cfg_busy) busy_ok = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input vec_t v, output int lat, output bit seen,
                                  output bit busy_ok, output logic [7:0] rdata);
        model_resp        = v.resp;
        cfg_bus.cfg_wr    = v.wr;
        cfg_bus.cfg_addr  = v.addr;
        cfg_bus.cfg_wdata = v.wdata;
        cfg_bus.cfg_req   = 1'b1;
        wait_ack(400, lat, seen, busy_ok);
        rdata = cfg_bus.cfg_rdata;
        tick();
        cfg_bus.cfg_req   = 1'b0;
        cfg_bus.cfg_wr    = ~v.wr;
        cfg_bus.cfg_addr  = ~v.addr;
        cfg_bus.cfg_wdata = ~v.wdata;
        repeat (4) tick();
    endtask

    task automatic check_output(input int i, input vec_t v, input int lat, input bit seen,
                                input bit busy_ok, input logic [7:0] rdata);
        rec_t r;
        bit   ok;
        check($sformatf("v%0d_ack_seen", i), seen, 1);
        check($sformatf("v%0d_latency", i), lat, v.exp_lat);
        check($sformatf("v%0d_busy_held", i), busy_ok, 1);
        check($sformatf("v%0d_rdata", i), rdata, v.exp_rdata);
        pop_rec(r, ok);
        check($sformatf("v%0d_frame_present", i), ok, 1);
        check($sformatf("v%0d_frame", i), r.frame, v.exp_frame);
        check($sformatf("v%0d_csb_low", i), r.low, CSB_LOW);
        check($sformatf("v%0d_sdio_stable", i), r.sdio_err, 0);
        check($sformatf("v%0d_oe", i), r.oe_err, 0);
    endtask

    // Test sequence: reset, init table, vector table, reset mid-frame, held-off and back-to-back requests.
    initial begin
        int   n, hcount, lat;
        bit   seen, busy_ok, ok, held_ok;
        logic [7:0] rdata;
        rec_t r;

        vecs[0] = '{1'b1, 13'h00D,  8'h5A, 8'h00, 24'h000D5A, 8'h00, 107};
        vecs[1] = '{1'b0, 13'h001,  8'h77, 8'hA5, 24'h800100, 8'hA5, 107};
        vecs[2] = '{1'b1, 13'h1FFF, 8'hFF, 8'h00, 24'h1FFFFF, 8'hA5, 107};
        vecs[3] = '{1'b0, 13'h1ABC, 8'h00, 8'h3C, 24'h9ABC00, 8'h3C, 107};
        vecs[4] = '{1'b1, 13'h000,  8'h00, 8'h00, 24'h000000, 8'h3C, 107};
        vecs[5] = '{1'b0, 13'h0FF,  8'h00, 8'h00, 24'h80FF00, 8'h00, 107};

        reset_n = 1'b0;
        cfg_bus.cfg_req = 1'b0; cfg_bus.cfg_wr = 1'b0;
        cfg_bus.cfg_addr = '0;  cfg_bus.cfg_wdata = '0;
        model_resp = 8'h00;
        repeat (4) tick();
        check("reset_spi_pins", {adc_cs_n, adc_sclk, adc_sdio_o, adc_sdio_oe}, 4'b1000);
        check("reset_handshake", {cfg_bus.cfg_ack, cfg_bus.cfg_busy, init_done}, 3'b000);
        check("reset_rdata", cfg_bus.cfg_rdata, 8'h00);

        reset_n = 1'b1;
        n = 0; hcount = 0; seen = 1'b0;
        while (!seen && n < 2000) begin
            tick(); n++;
            if (adc_cs_n) hcount++; else hcount = 0;
            if (init_done) seen = 1'b1;
        end
        check("init_done_seen", seen, 1);
        check("init_done_delay", hcount, GAP_CYC + 1);
        check("init_frame_count", rec_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            pop_rec(r, ok);
            check($sformatf("init%0d_frame", i), r.frame, init_frames[i]);
            check($sformatf("init%0d_csb_low", i), r.low, CSB_LOW);
            if (i > 0) check($sformatf("init%0d_csb_high", i), r.high_before, GAP_CYC);
        end

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i], lat, seen, busy_ok, rdata);
            check_output(i, vecs[i], lat, seen, busy_ok, rdata);
        end

        rec_q.delete();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        n = 0;
        while (!(rec_q.size() == 1 && in_frame && rises == 12) && n < 1000) begin
            tick(); n++;
        end
        check("entry1_bit12_reached", n < 1000, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_cs_n", adc_cs_n, 1);
        check("async_reset_sclk", adc_sclk, 0);
        check("async_reset_init_done", init_done, 0);
        repeat (2) tick();
        rec_q.delete();
        reset_n = 1'b1;

        model_resp        = 8'h00;
        cfg_bus.cfg_wr    = 1'b1;
        cfg_bus.cfg_addr  = 13'h055;
        cfg_bus.cfg_wdata = 8'h33;
        cfg_bus.cfg_req   = 1'b1;
        n = 0; held_ok = 1'b1;
        while (!init_done && n < 2000) begin
            tick(); n++;
            if (!init_done && cfg_bus.cfg_busy) held_ok = 1'b0;
        end
        check("held_off_busy_low", held_ok, 1);
        n = 0;
        while (adc_cs_n && n < 50) begin
            tick(); n++;
        end
        cfg_bus.cfg_wr    = 1'b0;
        cfg_bus.cfg_addr  = 13'h1234;
        cfg_bus.cfg_wdata = 8'h99;
        wait_ack(400, lat, seen, busy_ok);
        check("held_req_ack_seen", seen, 1);
        tick();
        cfg_bus.cfg_req = 1'b0;
        repeat (150) tick();
        check("restart_frame_count", rec_q.size(), 4);
        for (int i = 0; i < 3; i++) begin
            pop_rec(r, ok);
            check($sformatf("restart%0d_frame", i), r.frame, init_frames[i]);
        end
        pop_rec(r, ok);
        check("held_req_frame", r.frame, 24'h005533);
        check("held_req_oe", r.oe_err, 0);

        cfg_bus.cfg_wr    = 1'b1;
        cfg_bus.cfg_addr  = 13'h0AA;
        cfg_bus.cfg_wdata = 8'hC3;
        cfg_bus.cfg_req   = 1'b1;
        wait_ack(400, lat, seen, busy_ok);
        check("b2b_ack1_seen", seen, 1);
        wait_ack(400, lat, seen, busy_ok);
        check("b2b_ack2_seen", seen, 1);
        tick();
        cfg_bus.cfg_req = 1'b0;
        repeat (150) tick();
        check("b2b_frame_count", rec_q.size(), 2);
        pop_rec(r, ok);
        check("b2b_frame1", r.frame, 24'h00AAC3);
        pop_rec(r, ok);
        check("b2b_frame2", r.frame, 24'h00AAC3);
        check("b2b_gap_min", r.high_before >= GAP_CYC, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
